// File: rtl/mem_stage_stall.sv
// MEM pipeline stage: branch resolution, sub-word loads/stores against a
// wait-stated data memory, upstream stall generation and the MEM/WB register.
module mem_stage_stall #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned DM_DEPTH   = 256,
  parameter int unsigned DM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_zero,
  input  logic [DATA_W-1:0] i_read_data2,
  input  logic [REG_W-1:0]  i_write_reg,
  input  logic [1:0]        i_WB_control,
  input  logic [2:0]        i_MEM_control,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_stall,
  output logic              o_branch,
  output logic [ADDR_W-1:0] o_branch_pc,
  output logic              o_valid,
  output logic [REG_W-1:0]  o_write_reg,
  output logic [DATA_W-1:0] o_write_data,
  output logic [DATA_W-1:0] o_result,
  output logic [1:0]        o_WB_control,
  output logic              o_misalign
);

  localparam int unsigned IDX_W    = $clog2(DM_DEPTH);
  localparam int unsigned SH_W     = $clog2(DATA_W);
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned LAT_M1   = (DM_LATENCY > 0) ? (DM_LATENCY - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_M1);
  localparam logic       HAS_WAIT  = (DM_LATENCY != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              mem_branch_c;
  logic              mem_rd_c;
  logic              mem_wr_c;
  logic              is_byte_c;
  logic              is_half_c;
  logic              aligned_c;
  logic              mem_req_c;
  logic              mop_c;
  logic              misalign_c;
  logic              stall_c;
  logic              final_c;
  logic              we_c;
  logic              load_c;
  logic [IDX_W-1:0]  idx_c;
  logic [SH_W-1:0]   byte_sh_c;
  logic [SH_W-1:0]   half_sh_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;

  logic [DATA_W-1:0] mem [DM_DEPTH];

  // Control decode and alignment check
  assign mem_branch_c = i_MEM_control[0];
  assign mem_rd_c     = i_MEM_control[1];
  assign mem_wr_c     = i_MEM_control[2];
  assign is_byte_c    = (i_size == 2'b00);
  assign is_half_c    = (i_size == 2'b01);
  assign aligned_c    = is_byte_c
                      | (is_half_c & ~i_result[0])
                      | (~is_byte_c & ~is_half_c & (i_result[1:0] == 2'b00));
  assign mem_req_c    = i_valid & (mem_rd_c | mem_wr_c);
  assign mop_c        = mem_req_c & aligned_c;
  assign misalign_c   = mem_req_c & ~aligned_c;
  assign load_c       = mop_c & mem_rd_c;

  // Branch resolves immediately, independent of any memory stall
  assign o_branch    = i_valid & mem_branch_c & i_zero;
  assign o_branch_pc = i_branch_pc;

  // Stall while the access still has wait states ahead of it
  always_comb begin
    stall_c = 1'b0;
    final_c = 1'b0;
    if (state == S_IDLE) begin
      stall_c = mop_c & HAS_WAIT;
      final_c = mop_c & ~HAS_WAIT;
    end else begin
      stall_c = (cnt != '0);
      final_c = (cnt == '0) & mop_c;
    end
  end

  assign o_stall = stall_c;

  // Wait-state sequencer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mop_c && HAS_WAIT) begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Word addressing wraps modulo the memory size; lanes are little-endian
  assign idx_c     = i_result[IDX_W+1:2];
  assign byte_sh_c = SH_W'({i_result[1:0], 3'b000});
  assign half_sh_c = SH_W'({i_result[1], 4'b0000});
  assign rd_word_c = mem[idx_c];

  // Merge store data into the selected lanes of the current word
  always_comb begin
    wr_word_c = rd_word_c;
    if (is_byte_c) begin
      wr_word_c[byte_sh_c +: 8] = i_read_data2[7:0];
    end else if (is_half_c) begin
      wr_word_c[half_sh_c +: 16] = i_read_data2[15:0];
    end else begin
      wr_word_c = i_read_data2;
    end
  end

  // Reset blocks a write that would otherwise land on the aborting edge
  assign we_c = final_c & mem_wr_c & i_rst_n;

  // Data memory array; contents survive reset
  always_ff @(posedge i_clk) begin
    if (we_c) begin
      mem[idx_c] <= wr_word_c;
    end
  end

  // Lane select and sign/zero extension of load data
  always_comb begin
    ld_byte_c = rd_word_c[byte_sh_c +: 8];
    ld_half_c = rd_word_c[half_sh_c +: 16];
    ld_data_c = rd_word_c;
    if (is_byte_c) begin
      ld_data_c = i_unsigned ? DATA_W'(ld_byte_c)
                             : {{(DATA_W-8){ld_byte_c[7]}}, ld_byte_c};
    end else if (is_half_c) begin
      ld_data_c = i_unsigned ? DATA_W'(ld_half_c)
                             : {{(DATA_W-16){ld_half_c[15]}}, ld_half_c};
    end
  end

  // MEM/WB register; stall cycles become bubbles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_write_reg  <= '0;
      o_write_data <= '0;
      o_result     <= '0;
      o_WB_control <= 2'b00;
      o_misalign   <= 1'b0;
    end else if (stall_c) begin
      o_valid      <= 1'b0;
      o_WB_control <= 2'b00;
      o_misalign   <= 1'b0;
    end else begin
      o_valid      <= i_valid;
      o_write_reg  <= i_write_reg;
      o_write_data <= load_c ? ld_data_c : '0;
      o_result     <= i_result;
      o_WB_control <= misalign_c ? 2'b00 : i_WB_control;
      o_misalign   <= misalign_c;
    end
  end

endmodule

// File: tb/tb_mem_stage_stall.sv
// Directed bench for mem_stage_stall: a DM_LATENCY=2 and a DM_LATENCY=0
// instance share stimulus; a byte-level memory model feeds a scoreboard.
module tb_mem_stage_stall;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_branch_pc;
  logic [31:0] i_result;
  logic        i_zero;
  logic [31:0] i_read_data2;
  logic [4:0]  i_write_reg;
  logic [1:0]  i_WB_control;
  logic [2:0]  i_MEM_control;
  logic [1:0]  i_size;
  logic        i_unsigned;

  logic        stall2, branch2, valid2, mis2;
  logic [31:0] bpc2, wdata2, result2;
  logic [4:0]  wreg2;
  logic [1:0]  wb2;
  logic        stall0, branch0, valid0, mis0;
  logic [31:0] bpc0, wdata0, result0;
  logic [4:0]  wreg0;
  logic [1:0]  wb0;

  mem_stage_stall #(.DM_LATENCY(2)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_branch_pc(i_branch_pc),
    .i_result(i_result), .i_zero(i_zero), .i_read_data2(i_read_data2),
    .i_write_reg(i_write_reg), .i_WB_control(i_WB_control), .i_MEM_control(i_MEM_control),
    .i_size(i_size), .i_unsigned(i_unsigned), .o_stall(stall2), .o_branch(branch2),
    .o_branch_pc(bpc2), .o_valid(valid2), .o_write_reg(wreg2), .o_write_data(wdata2),
    .o_result(result2), .o_WB_control(wb2), .o_misalign(mis2));

  mem_stage_stall #(.DM_LATENCY(0)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_branch_pc(i_branch_pc),
    .i_result(i_result), .i_zero(i_zero), .i_read_data2(i_read_data2),
    .i_write_reg(i_write_reg), .i_WB_control(i_WB_control), .i_MEM_control(i_MEM_control),
    .i_size(i_size), .i_unsigned(i_unsigned), .o_stall(stall0), .o_branch(branch0),
    .o_branch_pc(bpc0), .o_valid(valid0), .o_write_reg(wreg0), .o_write_data(wdata0),
    .o_result(result0), .o_WB_control(wb0), .o_misalign(mis0));

  always #5 i_clk = ~i_clk;

  bit          use0 = 1'b0;
  logic        s_stall, s_branch, s_valid, s_mis;
  logic [31:0] s_bpc, s_wdata, s_result;
  logic [4:0]  s_wreg;
  logic [1:0]  s_wb;

  assign s_stall  = use0 ? stall0  : stall2;
  assign s_branch = use0 ? branch0 : branch2;
  assign s_valid  = use0 ? valid0  : valid2;
  assign s_mis    = use0 ? mis0    : mis2;
  assign s_bpc    = use0 ? bpc0    : bpc2;
  assign s_wdata  = use0 ? wdata0  : wdata2;
  assign s_result = use0 ? result0 : result2;
  assign s_wreg   = use0 ? wreg0   : wreg2;
  assign s_wb     = use0 ? wb0     : wb2;

  typedef struct {
    logic        v;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic [31:0] result;
    logic [1:0]  wb;
    logic        mis;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mb2 [1024];
  logic [7:0]  mb0 [1024];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rdb(input int a);
    return use0 ? mb0[a] : mb2[a];
  endfunction

  task automatic wrb(input int a, input logic [7:0] d);
    if (use0) mb0[a] = d;
    else      mb2[a] = d;
  endtask

  // Drive one EX/MEM entry, ride out its stall window, check the MEM/WB result
  task automatic op(input string tag, input logic rd, input logic wr, input logic br,
                    input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic v, input logic z,
                    input logic [4:0] wreg, input logic [1:0] wb);
    exp_t        e;
    exp_t        got;
    logic        aligned, req, mop;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    int          a, nb, cyc;

    a       = int'(addr & 32'h3FF);
    aligned = (sz == 2'b00) ? 1'b1 : (sz == 2'b01) ? ~addr[0] : (addr[1:0] == 2'b00);
    req     = v & (rd | wr);
    mop     = req & aligned;
    ld      = 32'h0;
    if (mop && rd) begin
      case (sz)
        2'b00: begin
          b  = rdb(a);
          ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        2'b01: begin
          h  = {rdb(a + 1), rdb(a)};
          ld = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: ld = {rdb(a + 3), rdb(a + 2), rdb(a + 1), rdb(a)};
      endcase
    end
    if (mop && wr) begin
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) wrb(a + i, wdata[8*i +: 8]);
    end
    e.v      = v;
    e.wreg   = wreg;
    e.data   = ld;
    e.result = addr;
    e.wb     = (req && !aligned) ? 2'b00 : wb;
    e.mis    = req & ~aligned;
    e.stalls = (mop && !use0) ? 2 : 0;
    sb.push_back(e);

    @(negedge i_clk);
    i_valid       = v;
    i_MEM_control = {wr, rd, br};
    i_size        = sz;
    i_unsigned    = uns;
    i_result      = addr;
    i_read_data2  = wdata;
    i_zero        = z;
    i_write_reg   = wreg;
    i_WB_control  = wb;
    i_branch_pc   = ~addr;
    #1;
    chk({tag, "_branch"}, 32'(s_branch), 32'(v & br & z));
    chk({tag, "_branch_pc"}, s_bpc, ~addr);

    cyc = 0;
    while (s_stall && cyc < 16) begin
      @(posedge i_clk);
      #1;
      cyc++;
      chk({tag, "_bubble_valid"}, 32'(s_valid), 32'h0);
      chk({tag, "_bubble_wb"}, 32'(s_wb), 32'h0);
    end
    @(posedge i_clk);
    #1;
    got = sb.pop_front();
    chk({tag, "_stall_cycles"}, 32'(cyc), 32'(got.stalls));
    chk({tag, "_valid"}, 32'(s_valid), 32'(got.v));
    chk({tag, "_write_reg"}, 32'(s_wreg), 32'(got.wreg));
    chk({tag, "_write_data"}, s_wdata, got.data);
    chk({tag, "_result"}, s_result, got.result);
    chk({tag, "_wb"}, 32'(s_wb), 32'(got.wb));
    chk({tag, "_misalign"}, 32'(s_mis), 32'(got.mis));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(s_valid), 32'h0);
    chk({tag, "_write_reg"}, 32'(s_wreg), 32'h0);
    chk({tag, "_write_data"}, s_wdata, 32'h0);
    chk({tag, "_result"}, s_result, 32'h0);
    chk({tag, "_wb"}, 32'(s_wb), 32'h0);
    chk({tag, "_misalign"}, 32'(s_mis), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mb2[i] = 8'h00;
      mb0[i] = 8'h00;
    end
    i_rst_n = 1'b0; i_valid = 1'b0; i_branch_pc = '0; i_result = '0; i_zero = 1'b0;
    i_read_data2 = '0; i_write_reg = '0; i_WB_control = '0; i_MEM_control = '0;
    i_size = '0; i_unsigned = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_outputs("por");
    chk("por_stall", 32'(s_stall), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Seed 0x10, then abort an overwrite by reset in the middle of WAIT
    op("sw_seed", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h11111111, 1'b1, 1'b0, 5'd0, 2'b00);
    @(negedge i_clk);
    i_valid = 1'b1; i_MEM_control = 3'b100; i_size = 2'b10; i_result = 32'h10;
    i_read_data2 = 32'hDEADBEEF; i_write_reg = 5'd7; i_WB_control = 2'b11;
    @(posedge i_clk);
    #1;
    chk("rst_mid_stall", 32'(s_stall), 32'h1);
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    chk("rst_mid_idle", 32'(s_stall), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    op("lw_after_abort", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd3, 2'b11);

    // Word store/load and sub-word extension
    op("sw_beef", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 2'b00);
    op("lw_beef", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd4, 2'b11);
    op("lb_13", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 5'd5, 2'b11);
    op("lbu_13", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 5'd6, 2'b11);
    op("sh_12", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 1'b1, 1'b0, 5'd0, 2'b00);
    op("lw_merged", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd8, 2'b11);
    op("lh_10", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd9, 2'b11);
    op("lhu_12", 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 5'd10, 2'b11);
    op("lw_size11", 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd11, 2'b10);

    // Misaligned accesses leave memory untouched and never stall
    op("lw_mis", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 5'd12, 2'b11);
    op("lh_mis", 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 5'd13, 2'b11);
    op("sw_mis", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, 1'b1, 1'b0, 5'd0, 2'b01);
    op("lw_unchanged", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 5'd14, 2'b11);

    // Address wrap-around modulo the memory size
    op("sw_wrap", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h55, 1'b1, 1'b0, 5'd0, 2'b00);
    op("lw_wrap", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd15, 2'b11);
    op("sb_wrap", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h401, 32'h12345677, 1'b1, 1'b0, 5'd0, 2'b00);
    op("lw_wrap2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd16, 2'b11);

    // Invalid entry and branch resolution
    op("lw_invalid", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 5'd17, 2'b11);
    op("beq_taken", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 5'd0, 2'b00);
    op("beq_nottaken", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h84, 32'h0, 1'b1, 1'b0, 5'd0, 2'b00);
    op("beq_invalid", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h88, 32'h0, 1'b0, 1'b1, 5'd0, 2'b00);
    op("beq_load", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd18, 2'b11);

    // Zero-latency instance: back-to-back accesses never stall
    use0 = 1'b1;
    op("z_sw", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'hA5A55A5A, 1'b1, 1'b0, 5'd0, 2'b00);
    op("z_lw", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 5'd19, 2'b11);
    op("z_sb", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h00000080, 1'b1, 1'b0, 5'd0, 2'b00);
    op("z_lb", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 1'b1, 1'b0, 5'd20, 2'b11);
    op("z_lw2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 5'd21, 2'b11);
    op("z_beq", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h90, 32'h0, 1'b1, 1'b1, 5'd0, 2'b00);

    @(negedge i_clk);
    i_valid = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
